// File: rtl/sn54173_quad_flip_flop_pkg.sv
// ============================================================================
// Module      : sn54173_quad_flip_flop_pkg
// Description : Shared types for the SN54173-style register: per-bit cell
//               operation encoding and the clear/load priority decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sn54173_quad_flip_flop_pkg;

    localparam int C_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_CLEAR = 2'd2
    } cell_op_e;

    // Clear dominates a simultaneous load; either disable line blocks loading.
    function automatic cell_op_e decode_op(input logic clr, input logic g1, input logic g2);
        if (clr)
            return OP_CLEAR;
        else if (!g1 && !g2)
            return OP_LOAD;
        else
            return OP_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sn54173_dff_cell.sv
// ============================================================================
// Module      : sn54173_dff_cell
// Description : One storage bit with synchronous clear / load / hold select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sn54173_dff_cell
    import sn54173_quad_flip_flop_pkg::*;
(
    input  logic     clk,
    input  cell_op_e op_i,
    input  logic     d_i,
    output logic     q_o
);

    logic stored_q;
    logic stored_d;

    always_comb begin
        stored_d = stored_q;
        unique case (op_i)
            OP_CLEAR: stored_d = 1'b0;
            OP_LOAD:  stored_d = d_i;
            default:  stored_d = stored_q;
        endcase
    end

    always_ff @(posedge clk) begin
        stored_q <= stored_d;
    end

    assign q_o = stored_q;

endmodule

`default_nettype wire

// File: rtl/sn54173_quad_flip_flop.sv
// ============================================================================
// Module      : sn54173_quad_flip_flop
// Description : WIDTH-bit register with gated load, synchronous clear and a
//               shared active-low three-state output enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sn54173_quad_flip_flop
    import sn54173_quad_flip_flop_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             g1,
    input  logic             g2,
    input  logic             m,
    input  logic             n,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    cell_op_e         w_op;
    logic [WIDTH-1:0] w_stored;
    logic             w_oe;

    assign w_op = decode_op(clr, g1, g2);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            sn54173_dff_cell u_cell (
                .clk  (clk),
                .op_i (w_op),
                .d_i  (data[i]),
                .q_o  (w_stored[i])
            );
        end
    endgenerate

    // Output enable is purely combinational; storage keeps running when disabled.
    assign w_oe = !m && !n;
    assign q    = w_oe ? w_stored : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_sn54173_quad_flip_flop.sv
// ============================================================================
// Module      : tb_sn54173_quad_flip_flop
// Description : Self-checking bench with a behavioural model of the register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sn54173_quad_flip_flop;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             g1  = 1'b1;
    logic             g2  = 1'b1;
    logic             m   = 1'b1;
    logic             n   = 1'b1;
    logic [WIDTH-1:0] data = '0;
    wire  [WIDTH-1:0] q;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model;
    logic [WIDTH-1:0] hiz;

    sn54173_quad_flip_flop #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .clr  (clr),
        .g1   (g1),
        .g2   (g2),
        .m    (m),
        .n    (n),
        .data (data),
        .q    (q)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, applying the register rules to the model.
    task automatic step();
        @(posedge clk);
        if (clr === 1'b1)
            model = '0;
        else if (g1 === 1'b0 && g2 === 1'b0)
            model = data;
        #1;
    endtask

    function automatic logic [WIDTH-1:0] expected_q();
        if (m || n)
            return hiz;
        return model;
    endfunction

    task automatic test_reset();
        m = 0; n = 0; g1 = 0; g2 = 0; clr = 1; data = WIDTH'($urandom);
        step();
        checks++;
        if (q !== 4'b0000) begin
            errors++;
            $display("FAIL reset: q=%b expected=%b", q, 4'b0000);
        end
    endtask

    task automatic test_load();
        clr = 0; g1 = 0; g2 = 0; data = 4'b1010;
        step();
        checks++;
        if (q !== 4'b1010) begin
            errors++;
            $display("FAIL load: q=%b expected=%b", q, 4'b1010);
        end
    endtask

    task automatic test_hold();
        g1 = 1; g2 = 0; data = 4'b1100;
        step();
        checks++;
        if (q !== 4'b1010) begin
            errors++;
            $display("FAIL hold_g1: q=%b expected=%b", q, 4'b1010);
        end
        g1 = 0; g2 = 1;
        step();
        checks++;
        if (q !== 4'b1010) begin
            errors++;
            $display("FAIL hold_g2: q=%b expected=%b", q, 4'b1010);
        end
    endtask

    task automatic test_output_enable();
        g1 = 0; g2 = 0; data = 4'b1111;
        step();
        checks++;
        if (q !== 4'b1111) begin
            errors++;
            $display("FAIL load_ones: q=%b expected=%b", q, 4'b1111);
        end
        n = 1; #1;
        checks++;
        if (q !== hiz) begin
            errors++;
            $display("FAIL oe_n_high: q=%b expected=%b", q, hiz);
        end
        m = 1; n = 0; #1;
        checks++;
        if (q !== hiz) begin
            errors++;
            $display("FAIL oe_m_high: q=%b expected=%b", q, hiz);
        end
        m = 0; #1;
        checks++;
        if (q !== 4'b1111) begin
            errors++;
            $display("FAIL oe_reenable: q=%b expected=%b", q, 4'b1111);
        end
    endtask

    task automatic test_clear_while_disabled();
        m = 1; n = 1; clr = 1; g1 = 0; g2 = 0; data = 4'b0101;
        step();
        checks++;
        if (q !== hiz) begin
            errors++;
            $display("FAIL clr_disabled_z: q=%b expected=%b", q, hiz);
        end
        m = 0; n = 0; #1;
        checks++;
        if (q !== 4'b0000) begin
            errors++;
            $display("FAIL clr_wins: q=%b expected=%b", q, 4'b0000);
        end
        clr = 0;
    endtask

    task automatic test_sync_clear_only();
        clr = 0; g1 = 0; g2 = 0; data = 4'b0110;
        step();
        g1 = 1; data = 4'b1001;
        // Glitch clr, data and g2 strictly between edges.
        #1 clr = 1; g2 = 0;
        #2 clr = 0; data = 4'b0000;
        checks++;
        if (q !== 4'b0110) begin
            errors++;
            $display("FAIL clr_pulse_midcycle: q=%b expected=%b", q, 4'b0110);
        end
        step();
        checks++;
        if (q !== 4'b0110) begin
            errors++;
            $display("FAIL clr_pulse_next_edge: q=%b expected=%b", q, 4'b0110);
        end
        // Momentary load enable between edges must not capture either.
        #1 g1 = 0; data = 4'b1111;
        #2 g1 = 1;
        step();
        checks++;
        if (q !== 4'b0110) begin
            errors++;
            $display("FAIL gate_pulse_midcycle: q=%b expected=%b", q, 4'b0110);
        end
    endtask

    task automatic test_back_to_back();
        g1 = 0; g2 = 0; clr = 0; m = 0; n = 0;
        for (int i = 0; i < 8; i++) begin
            data = WIDTH'($urandom);
            step();
            checks++;
            if (q !== expected_q()) begin
                errors++;
                $display("FAIL back_to_back[%0d]: q=%b expected=%b", i, q, expected_q());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            clr  = ($urandom_range(0, 7) == 0);
            g1   = ($urandom_range(0, 2) == 0);
            g2   = ($urandom_range(0, 2) == 0);
            m    = ($urandom_range(0, 3) == 0);
            n    = ($urandom_range(0, 3) == 0);
            data = WIDTH'($urandom);
            step();
            checks++;
            if (q !== expected_q()) begin
                errors++;
                $display("FAIL random_edge[%0d]: q=%b expected=%b", i, q, expected_q());
            end
            m = $urandom_range(0, 1) == 1;
            n = $urandom_range(0, 1) == 1;
            #1;
            checks++;
            if (q !== expected_q()) begin
                errors++;
                $display("FAIL random_oe[%0d]: q=%b expected=%b", i, q, expected_q());
            end
        end
    endtask

    initial begin
        hiz   = 4'bzzzz;
        model = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_hold();
        test_output_enable();
        test_clear_while_disabled();
        test_sync_clear_only();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
